alu_op_driver: RTL and testbench

Issue/collect front end for the 3-stage pipelined mini ALU. Accepts tagged operations from a host over a valid/ready handshake, drives them onto the ALU's operand and control inputs, and tracks each operation through the fixed-latency ALU pipeline. Captures each `z`/`zero` result with its tag into a small result FIFO, presented to the host over a second valid/ready handshake. The ALU cannot stall, so issue is credit-limited and a captured result is never dropped.

---
 rtl/alu_op_driver_pkg.sv | 24 ++
 rtl/alu_op_driver_if.sv | 35 +++
 rtl/alu_op_driver_fifo.sv | 64 ++++++
 rtl/alu_op_driver.sv | 119 +++++++++++
 tb/tb_alu_op_driver.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_op_driver_pkg.sv
// Shared types and defaults for the mini-ALU issue/collect front end.
//   alu_op_e  : ALU opcode encoding as driven on the ALU ctrl input
//   alu_res_t : packed result record {z, zero, tag} at default widths
//   ALU_*     : default operand width, pipeline latency and tag width
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_op_e;

  localparam int unsigned ALU_WIDTH = 4;
  localparam int unsigned ALU_LAT   = 3;
  localparam int unsigned ALU_TAGW  = 2;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] z;
    logic                 zero;
    logic [ALU_TAGW-1:0]  tag;
  } alu_res_t;

endpackage

// File: rtl/alu_op_driver_if.sv
// Host-side bundle for alu_op_driver: operation request channel (op_*) and
// result return channel (res_*), each a valid/ready handshake.
//   master : the host (drives op_*, res_ready)
//   slave  : alu_op_driver (drives op_ready, res_*)
interface alu_op_driver_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned TAGW  = ALU_TAGW
);

  logic             op_valid;
  logic             op_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       op_ctrl;
  logic [TAGW-1:0]  op_tag;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_z;
  logic             res_zero;
  logic [TAGW-1:0]  res_tag;

  modport master (
    output op_valid, op_a, op_b, op_ctrl, op_tag, res_ready,
    input  op_ready, res_valid, res_z, res_zero, res_tag
  );

  modport slave (
    input  op_valid, op_a, op_b, op_ctrl, op_tag, res_ready,
    output op_ready, res_valid, res_z, res_zero, res_tag
  );

endinterface

// File: rtl/alu_op_driver_fifo.sv
// alu_result_fifo: synchronous first-word-fall-through FIFO for ALU results.
//   clk, rst          : clock, asynchronous active-high reset
//   wr_en, wr_data    : push (ignored only if full and not popping)
//   rd_en, rd_data    : pop; rd_data shows the head, zero when empty
//   empty, count      : occupancy status
module alu_result_fifo #(
  parameter int unsigned W     = 7,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_wr;
  logic          do_rd;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_rd   = rd_en && !empty;
  // A write while full is legal only when the head leaves on the same edge;
  // the freed slot is then exactly the one wr_ptr points at.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= ptr_next(wr_ptr);
      if (do_rd) rd_ptr <= ptr_next(rd_ptr);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_driver.sv
// alu_op_driver: issue/collect front end for the fixed-latency mini ALU.
//   clk, rst            : clock, asynchronous active-high reset
//   host (slave)        : op_* request handshake in, res_* result handshake out
//   alu_a/alu_b/alu_ctrl: registered operands/opcode to the ALU
//   alu_z/alu_zero      : ALU result, valid LAT cycles after alu_* is driven
// Issue is credit-limited so every captured result has a FIFO slot.
module alu_op_driver
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned LAT   = ALU_LAT,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAGW  = ALU_TAGW
) (
  input  logic             clk,
  input  logic             rst,
  alu_op_driver_if.slave   host,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_z,
  input  logic             alu_zero
);

  localparam int unsigned RW     = WIDTH + 1 + TAGW;
  localparam int unsigned CW     = $clog2(DEPTH + 1);
  // Stage 0 lines up with the issue register (op on alu_*); the remaining
  // LAT stages follow the ALU pipeline, so the last stage is valid exactly
  // in the cycle the ALU presents that op's result.
  localparam int unsigned STAGES = LAT + 1;

  logic              accept;
  logic              capture;
  logic              pop;
  logic [STAGES-1:0] fl_vld;
  logic [TAGW-1:0]   fl_tag [STAGES];
  logic [CW-1:0]     inflight_count;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       credit_used;
  alu_op_e           ctrl_q;
  logic [RW-1:0]     fifo_wdata;
  logic [RW-1:0]     fifo_rdata;
  logic              fifo_empty;

  assign accept      = host.op_valid && host.op_ready;
  assign capture     = fl_vld[STAGES-1];
  assign pop         = host.res_valid && host.res_ready;
  assign credit_used = {1'b0, inflight_count} + {1'b0, fifo_count};
  assign host.op_ready = (credit_used < (CW + 1)'(DEPTH));

  // Issue registers: idle cycles drive ADD 0+0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a  <= '0;
      alu_b  <= '0;
      ctrl_q <= ALU_ADD;
    end else if (accept) begin
      alu_a  <= host.op_a;
      alu_b  <= host.op_b;
      ctrl_q <= alu_op_e'(host.op_ctrl);
    end else begin
      alu_a  <= '0;
      alu_b  <= '0;
      ctrl_q <= ALU_ADD;
    end
  end

  assign alu_ctrl = ctrl_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fl_vld <= '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        fl_tag[i] <= '0;
      end
    end else begin
      fl_vld    <= {fl_vld[STAGES-2:0], accept};
      fl_tag[0] <= host.op_tag;
      for (int unsigned i = 1; i < STAGES; i++) begin
        fl_tag[i] <= fl_tag[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_count <= '0;
    end else begin
      case ({accept, capture})
        2'b10:   inflight_count <= inflight_count + CW'(1);
        2'b01:   inflight_count <= inflight_count - CW'(1);
        default: ;
      endcase
    end
  end

  assign fifo_wdata = {alu_z, alu_zero, fl_tag[STAGES-1]};

  alu_result_fifo #(
    .W     (RW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (capture),
    .wr_data (fifo_wdata),
    .rd_en   (host.res_ready),
    .rd_data (fifo_rdata),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign host.res_valid = !fifo_empty;
  assign host.res_z     = fifo_rdata[RW-1 -: WIDTH];
  assign host.res_zero  = fifo_rdata[TAGW];
  assign host.res_tag   = fifo_rdata[TAGW-1:0];

endmodule

// File: tb/tb_alu_op_driver.sv
// Self-checking bench for alu_op_driver with a behavioural LAT-cycle ALU.
// Expected behaviour comes from an op-level model: a queue of outstanding
// operations, each stamped with the cycle its result becomes visible.
module tb_alu_op_driver;
  import alu_pkg::*;

  localparam int W    = 4;
  localparam int LATP = 3;
  localparam int DEP  = 4;
  localparam int TW   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  alu_a, alu_b, alu_z;
  logic [1:0]    alu_ctrl;
  logic          alu_zero;

  alu_op_driver_if #(.WIDTH(W), .TAGW(TW)) hif ();

  alu_op_driver #(
    .WIDTH (W),
    .LAT   (LATP),
    .DEPTH (DEP),
    .TAGW  (TW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .host     (hif),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_ctrl (alu_ctrl),
    .alu_z    (alu_z),
    .alu_zero (alu_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] alu_math(input int a, input int b, input int c);
    int r;
    case (c)
      0:       r = a + b;
      1:       r = a - b;
      2:       r = a & b;
      default: r = a ^ b;
    endcase
    r = r & ((1 << W) - 1);
    return {(r == 0), r[W-1:0]};
  endfunction

  // Behavioural ALU: never reset, so stale results keep flowing after rst.
  logic [W:0] alu_pipe [LATP];
  always @(posedge clk) begin
    alu_pipe[0] <= alu_math(int'(alu_a), int'(alu_b), int'(alu_ctrl));
    for (int i = 1; i < LATP; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign {alu_zero, alu_z} = alu_pipe[LATP-1];

  typedef struct {
    logic [W-1:0]  z;
    logic          zero;
    logic [TW-1:0] tag;
    int            avail;
  } exp_t;

  exp_t          pend[$];
  int            cyc = 0;
  logic [W-1:0]  exp_a = '0, exp_b = '0;
  logic [1:0]    exp_ctrl = '0;
  int            checks = 0, errors = 0;
  logic          last_acc, last_rv, last_zero;
  logic [W-1:0]  last_z;
  logic [TW-1:0] last_tag;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: inputs already set; check at negedge, advance model.
  task automatic tick();
    int         nfifo;
    logic       mready, mvalid, mpop;
    logic [W:0] r;
    exp_t       e;
    @(negedge clk);
    nfifo = 0;
    foreach (pend[i]) if (pend[i].avail <= cyc) nfifo++;
    mready = (pend.size() < DEP);
    mvalid = (pend.size() > 0) && (pend[0].avail <= cyc);
    check("op_ready", hif.op_ready, mready);
    check("res_valid", hif.res_valid, mvalid);
    if (mvalid) begin
      check("res_z", hif.res_z, pend[0].z);
      check("res_zero", hif.res_zero, pend[0].zero);
      check("res_tag", hif.res_tag, pend[0].tag);
    end
    check("alu_a", alu_a, exp_a);
    check("alu_b", alu_b, exp_b);
    check("alu_ctrl", alu_ctrl, exp_ctrl);
    check("fifo_count", dut.fifo_count, nfifo);
    check("capture_into_full", dut.capture && (dut.fifo_count == DEP) && !dut.pop, 0);
    last_acc  = hif.op_valid && mready;
    last_rv   = hif.res_valid;
    last_z    = hif.res_z;
    last_zero = hif.res_zero;
    last_tag  = hif.res_tag;
    mpop = mvalid && hif.res_ready;
    if (mpop) void'(pend.pop_front());
    if (last_acc) begin
      r       = alu_math(int'(hif.op_a), int'(hif.op_b), int'(hif.op_ctrl));
      e.z     = r[W-1:0];
      e.zero  = r[W];
      e.tag   = hif.op_tag;
      e.avail = cyc + 2 + LATP;
      pend.push_back(e);
    end
    exp_a    = last_acc ? hif.op_a : '0;
    exp_b    = last_acc ? hif.op_b : '0;
    exp_ctrl = last_acc ? hif.op_ctrl : '0;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check("rst_op_ready", hif.op_ready, 1);
    check("rst_res_valid", hif.res_valid, 0);
    check("rst_res_z", hif.res_z, 0);
    check("rst_res_zero", hif.res_zero, 0);
    check("rst_res_tag", hif.res_tag, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_ctrl", alu_ctrl, 0);
    check("rst_fifo_count", dut.fifo_count, 0);
    pend.delete();
    exp_a = '0; exp_b = '0; exp_ctrl = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_op(input int a, input int b, input int c, input int t);
    hif.op_a    = W'(a);
    hif.op_b    = W'(b);
    hif.op_ctrl = 2'(c);
    hif.op_tag  = TW'(t);
  endtask

  task automatic issue_one(input int a, input int b, input int c, input int t,
                           input int ez, input int ezero);
    int c0, seen;
    bit done;
    set_op(a, b, c, t);
    hif.op_valid  = 1'b1;
    hif.res_ready = 1'b1;
    done = 0;
    c0   = cyc;
    for (int k = 0; k < 20 && !done; k++) begin
      c0 = cyc;
      tick();
      done = last_acc;
    end
    hif.op_valid = 1'b0;
    check("dir_accept", done, 1);
    seen = -1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (last_rv && seen < 0) begin
        seen = (cyc - 1) - c0;
        check("dir_z", last_z, ez);
        check("dir_zero", last_zero, ezero);
        check("dir_tag", last_tag, t);
      end
    end
    check("dir_latency", seen, 5);
  endtask

  int dir_a [7] = '{2, 7, 6, 9, 5, 15, 0};
  int dir_b [7] = '{3, 5, 3, 5, 5, 1, 1};
  int dir_c [7] = '{0, 1, 2, 3, 1, 0, 1};
  int dir_z [7] = '{5, 2, 2, 12, 0, 0, 15};
  int dir_f [7] = '{0, 0, 0, 0, 1, 1, 0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  hit;
    hif.op_valid  = 1'b0;
    hif.res_ready = 1'b1;
    set_op(0, 0, 0, 0);
    apply_reset();

    for (int i = 0; i < 7; i++)
      issue_one(dir_a[i], dir_b[i], dir_c[i], i % 4, dir_z[i], dir_f[i]);

    // Back-to-back, tags 0..3 twice.
    hif.res_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 60 && n < 8; k++) begin
      set_op($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3), n % 4);
      hif.op_valid = 1'b1;
      tick();
      if (last_acc) n++;
    end
    hif.op_valid = 1'b0;
    check("b2b_accepted", n, 8);
    for (int k = 0; k < 10; k++) tick();

    // Backpressure: offer 6 with results held.
    hif.res_ready = 1'b0;
    n = 0;
    for (int k = 0; k < 12 && n < 6; k++) begin
      set_op($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3), n % 4);
      hif.op_valid = 1'b1;
      tick();
      if (last_acc) n++;
    end
    hif.op_valid = 1'b0;
    check("bp_accepted", n, 4);
    hif.res_ready = 1'b1;
    for (int k = 0; k < 10; k++) tick();

    // Pop on the edge the last in-flight op is captured.
    hif.res_ready = 1'b0;
    n = 0;
    for (int k = 0; k < 20 && n < 4; k++) begin
      set_op($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3), k % 4);
      hif.op_valid = 1'b1;
      tick();
      if (last_acc) n++;
    end
    hif.op_valid = 1'b0;
    hit = 0;
    for (int k = 0; k < 20 && !hit; k++) begin
      hit = (pend.size() == 4) && (cyc + 1 == pend[3].avail);
      hif.res_ready = hit;
      tick();
    end
    check("pc_reached", hit, 1);
    hif.res_ready = 1'b0;
    tick();
    check("pc_count_hold", dut.fifo_count, 3);
    hif.res_ready = 1'b1;
    for (int k = 0; k < 8; k++) tick();

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      set_op($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3),
             $urandom_range(0, 3));
      hif.op_valid  = ($urandom_range(0, 3) != 0);
      hif.res_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    hif.op_valid  = 1'b0;
    hif.res_ready = 1'b1;
    for (int k = 0; k < 12; k++) tick();

    // Reset with three ops in flight.
    for (int k = 0; k < 3; k++) begin
      set_op(k + 1, 1, 0, k);
      hif.op_valid = 1'b1;
      tick();
    end
    hif.op_valid = 1'b0;
    tick();
    tick();
    apply_reset();
    n = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (last_rv) n++;
    end
    check("post_rst_stale", n, 0);
    issue_one(2, 3, 0, 0, 5, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
